// File: rtl/ps2_scancode_decoder.sv
// PS/2 scancode decoder: folds 0xE0/0xF0 prefixes into flags on the following
// terminal byte and queues {ext, rel, code} entries in a first-word-fall-through FIFO.
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_AW        = 3,
  parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         received_data,
  input  logic               received_data_en,
  input  logic               key_read,
  input  logic               overflow_clear,
  output logic [7:0]         key_code,
  output logic               key_extended,
  output logic               key_release,
  output logic               key_valid,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int unsigned      Depth    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DepthCnt = Depth[FIFO_AW:0];
  localparam logic [7:0]       ByteExt  = 8'hE0;
  localparam logic [7:0]       ByteRel  = 8'hF0;

  typedef enum logic [1:0] {StIdle, StExt, StRel, StExtRel} state_e;

  state_e      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [9:0]         mem_q [Depth];

  logic       cur_ext, cur_rel;
  logic       push, do_push, do_pop, full, ovf_evt;
  logic [9:0] push_entry, head;

  // Prefix flags implied by the current decoder state.
  always_comb begin
    cur_ext = 1'b0;
    cur_rel = 1'b0;
    unique case (state_q)
      StIdle:   begin cur_ext = 1'b0; cur_rel = 1'b0; end
      StExt:    begin cur_ext = 1'b1; cur_rel = 1'b0; end
      StRel:    begin cur_ext = 1'b0; cur_rel = 1'b1; end
      StExtRel: begin cur_ext = 1'b1; cur_rel = 1'b1; end
    endcase
  end

  // Decoder next state, prefix timeout and push request.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    push       = 1'b0;
    push_entry = {cur_ext, cur_rel, received_data};
    if (received_data_en) begin
      tmo_d = '0;
      if (received_data == ByteExt) begin
        state_d = cur_rel ? StExtRel : StExt;
      end else if (received_data == ByteRel) begin
        state_d = cur_ext ? StExtRel : StRel;
      end else begin
        push    = 1'b1;
        state_d = StIdle;
      end
    end else if (state_q != StIdle) begin
      // A prefix left dangling too long is stale; drop it silently.
      if (tmo_q + 16'd1 == PREFIX_TIMEOUT) begin
        state_d = StIdle;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
  end

  // FIFO bookkeeping: a pop frees the slot, so push-while-full succeeds with a pop.
  always_comb begin
    full     = (cnt_q == DepthCnt);
    do_pop   = key_read && (cnt_q != '0);
    do_push  = push && (!full || do_pop);
    ovf_evt  = push && full && !do_pop;
    wr_ptr_d = do_push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (FIFO_AW+1)'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - (FIFO_AW+1)'(1);
    end
    // Setting wins over clearing.
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (overflow_clear) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State, counters and pointers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      tmo_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are don't-care while not counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Head outputs, forced to zero when the FIFO is empty.
  always_comb begin
    head         = mem_q[rd_ptr_q];
    key_valid    = (cnt_q != '0);
    key_code     = key_valid ? head[7:0] : 8'h00;
    key_release  = key_valid & head[8];
    key_extended = key_valid & head[9];
    fifo_count   = cnt_q;
    overflow     = ovf_q;
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_ps2_scancode_decoder;

  localparam int unsigned AW    = 3;
  localparam int          DEPTH = 8;
  localparam logic [15:0] TMO   = 16'd20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       key_read = 1'b0;
  logic       overflow_clear = 1'b0;
  logic [7:0] key_code;
  logic       key_extended, key_release, key_valid, overflow;
  logic [AW:0] fifo_count;

  int checks = 0;
  int errors = 0;

  // Reference model: pending prefix flags, idle gap since last byte, entry queue.
  logic [9:0] mq[$];
  bit         m_ext, m_rel, m_ovf;
  int         m_gap;

  ps2_scancode_decoder #(
    .FIFO_AW        (AW),
    .PREFIX_TIMEOUT (TMO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .key_read         (key_read),
    .overflow_clear   (overflow_clear),
    .key_code         (key_code),
    .key_extended     (key_extended),
    .key_release      (key_release),
    .key_valid        (key_valid),
    .fifo_count       (fifo_count),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] ctl;   // {en, rd, clr}
    logic [2:0] vfl;   // {valid, ext, rel}
    logic [7:0] code;
    logic [3:0] cnt;
    logic       ovf;
  } vec_t;

  function automatic logic [15:0] mk_exp(logic v, logic [3:0] c, logic o, logic e, logic r,
                                         logic [7:0] code);
    return {v, c, o, e, r, code};
  endfunction

  function automatic logic [15:0] act_vec();
    return {key_valid, fifo_count, overflow, key_extended, key_release, key_code};
  endfunction

  function automatic logic [15:0] model_vec();
    logic [9:0] h;
    h = (mq.size() > 0) ? mq[0] : 10'h000;
    return mk_exp(mq.size() > 0, 4'(mq.size()), m_ovf, h[9], h[8], h[7:0]);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ext = 0; m_rel = 0; m_ovf = 0; m_gap = 0;
  endtask

  task automatic model_step(input logic [7:0] d, input logic en, input logic rd,
                            input logic clr);
    bit pop, push, full, evt;
    logic [9:0] ent;
    pop  = rd && (mq.size() > 0);
    push = 0;
    ent  = '0;
    if (en) begin
      m_gap = 0;
      if (d == 8'hE0) m_ext = 1;
      else if (d == 8'hF0) m_rel = 1;
      else begin
        push = 1;
        ent  = {m_ext, m_rel, d};
        m_ext = 0; m_rel = 0;
      end
    end else if (m_ext || m_rel) begin
      m_gap++;
      if (m_gap >= int'(TMO)) begin
        m_ext = 0; m_rel = 0; m_gap = 0;
      end
    end
    full = (mq.size() == DEPTH);
    evt  = push && full && !pop;
    if (pop) void'(mq.pop_front());
    if (push && !evt) mq.push_back(ent);
    if (evt) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  // One clock: drive, clock, advance model, compare against the model.
  task automatic cycle(input string nm, input logic [7:0] d, input logic en, input logic rd,
                       input logic clr);
    received_data    = d;
    received_data_en = en;
    key_read         = rd;
    overflow_clear   = clr;
    @(posedge clk);
    model_step(d, en, rd, clr);
    #1;
    chk(nm, act_vec(), model_vec());
    received_data_en = 1'b0;
    key_read         = 1'b0;
    overflow_clear   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle("drain", 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  vec_t tbl[21];

  initial begin
    tbl[0]  = '{8'h1C, 3'b100, 3'b100, 8'h1C, 4'd1, 1'b0};
    tbl[1]  = '{8'h00, 3'b010, 3'b000, 8'h00, 4'd0, 1'b0};
    tbl[2]  = '{8'hE0, 3'b100, 3'b000, 8'h00, 4'd0, 1'b0};
    tbl[3]  = '{8'hF0, 3'b100, 3'b000, 8'h00, 4'd0, 1'b0};
    tbl[4]  = '{8'h75, 3'b100, 3'b111, 8'h75, 4'd1, 1'b0};
    tbl[5]  = '{8'hAA, 3'b110, 3'b100, 8'hAA, 4'd1, 1'b0};
    tbl[6]  = '{8'hE0, 3'b100, 3'b100, 8'hAA, 4'd1, 1'b0};
    tbl[7]  = '{8'hE0, 3'b100, 3'b100, 8'hAA, 4'd1, 1'b0};
    tbl[8]  = '{8'h12, 3'b110, 3'b110, 8'h12, 4'd1, 1'b0};
    tbl[9]  = '{8'hF0, 3'b100, 3'b110, 8'h12, 4'd1, 1'b0};
    tbl[10] = '{8'hE0, 3'b100, 3'b110, 8'h12, 4'd1, 1'b0};
    tbl[11] = '{8'hF0, 3'b100, 3'b110, 8'h12, 4'd1, 1'b0};
    tbl[12] = '{8'h7C, 3'b100, 3'b110, 8'h12, 4'd2, 1'b0};
    tbl[13] = '{8'h00, 3'b010, 3'b111, 8'h7C, 4'd1, 1'b0};
    tbl[14] = '{8'h00, 3'b010, 3'b000, 8'h00, 4'd0, 1'b0};
    tbl[15] = '{8'h00, 3'b010, 3'b000, 8'h00, 4'd0, 1'b0};
    tbl[16] = '{8'hFF, 3'b100, 3'b100, 8'hFF, 4'd1, 1'b0};
    tbl[17] = '{8'h00, 3'b100, 3'b100, 8'hFF, 4'd2, 1'b0};
    tbl[18] = '{8'hFE, 3'b110, 3'b100, 8'h00, 4'd2, 1'b0};
    tbl[19] = '{8'h00, 3'b011, 3'b100, 8'hFE, 4'd1, 1'b0};
    tbl[20] = '{8'h00, 3'b010, 3'b000, 8'h00, 4'd0, 1'b0};

    model_reset();
    #3;
    chk("reset_state", act_vec(), 16'h0000);
    #20 reset = 1'b1;

    // Directed table from reset.
    foreach (tbl[i]) begin
      cycle("tbl_model", tbl[i].data, tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].ctl[0]);
      chk($sformatf("tbl[%0d]", i), act_vec(),
          mk_exp(tbl[i].vfl[2], tbl[i].cnt, tbl[i].ovf, tbl[i].vfl[1], tbl[i].vfl[0],
                 tbl[i].code));
    end

    // Prefix timeout: a full gap discards the prefix, one cycle less keeps it.
    cycle("tmo", 8'hF0, 1'b1, 1'b0, 1'b0);
    repeat (int'(TMO)) cycle("tmo_wait", 8'h00, 1'b0, 1'b0, 1'b0);
    cycle("tmo", 8'h1C, 1'b1, 1'b0, 1'b0);
    chk("tmo_expired", act_vec(), mk_exp(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'h1C));
    drain();
    cycle("tmo", 8'hF0, 1'b1, 1'b0, 1'b0);
    repeat (int'(TMO) - 1) cycle("tmo_wait", 8'h00, 1'b0, 1'b0, 1'b0);
    cycle("tmo", 8'h1C, 1'b1, 1'b0, 1'b0);
    chk("tmo_held", act_vec(), mk_exp(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 8'h1C));
    drain();

    // Overflow: nine bytes into eight slots.
    for (int i = 1; i <= 9; i++) cycle("ovf_fill", 8'(i), 1'b1, 1'b0, 1'b0);
    chk("ovf_full", act_vec(), mk_exp(1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 8'h01));
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_order", {8'h00, key_code}, {8'h00, 8'(i)});
      cycle("ovf_read", 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("ovf_empty", act_vec(), mk_exp(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00));
    cycle("ovf_clr", 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", {15'd0, overflow}, 16'd0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) cycle("full_fill", 8'h31 + 8'(i), 1'b1, 1'b0, 1'b0);
    cycle("full_rw", 8'h2A, 1'b1, 1'b1, 1'b0);
    chk("full_rw", act_vec(), mk_exp(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 8'h32));
    cycle("drop", 8'h0B, 1'b1, 1'b0, 1'b0);
    chk("drop", act_vec(), mk_exp(1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 8'h32));
    cycle("ovf_setwins", 8'h0C, 1'b1, 1'b0, 1'b1);
    chk("ovf_setwins", {15'd0, overflow}, 16'd1);
    cycle("ovf_clr2", 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk("full_order", {8'h00, key_code}, {8'h00, 8'h32 + 8'(i)});
      cycle("full_read", 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("full_last", act_vec(), mk_exp(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'h2A));
    drain();

    // Mid-operation reset with a pending prefix and queued entries.
    cycle("rst_fill", 8'h11, 1'b1, 1'b0, 1'b0);
    cycle("rst_fill", 8'h22, 1'b1, 1'b0, 1'b0);
    cycle("rst_fill", 8'h33, 1'b1, 1'b0, 1'b0);
    cycle("rst_fill", 8'hF0, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 chk("rst_async", act_vec(), 16'h0000);
    model_reset();
    #3 reset = 1'b1;
    cycle("rst_after", 8'h1C, 1'b1, 1'b0, 1'b0);
    chk("rst_after", act_vec(), mk_exp(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'h1C));
    drain();

    // Randomized traffic; sparse-strobe blocks exercise the timeout.
    for (int blk = 0; blk < 4; blk++) begin
      int en_div;
      en_div = (blk == 0) ? 2 : (blk == 1) ? 8 : (blk == 2) ? 30 : 2;
      for (int n = 0; n < 800; n++) begin
        logic [7:0] d;
        int sel;
        sel = int'($urandom_range(0, 7));
        d = (sel < 2) ? 8'hE0 : (sel == 2) ? 8'hF0 : 8'($urandom);
        cycle("rand", d, $urandom_range(0, en_div - 1) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter FIFO_AW, default 3, meaning FIFO address width (depth = 2**FIFO_AW entries).
REQ-002 SHALL have parameter PREFIX_TIMEOUT, default 16'd50000, meaning the number of clk cycles a pending prefix is held before it is discarded.
REQ-003 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port received_data  input  8  byte from the PS/2 receiver, valid only while received_data_en=1.
REQ-006 SHALL have port received_data_en  input  1  one-cycle strobe marking a new received byte.
REQ-007 SHALL have port key_read  input  1  pop request for the FIFO head entry.
REQ-008 SHALL have port overflow_clear  input  1  clears the overflow flag.
REQ-009 SHALL have port key_code  output  8  scancode of the FIFO head entry.
REQ-010 SHALL have port key_extended  output  1  head entry was preceded by 0xE0.
REQ-011 SHALL have port key_release  output  1  head entry was preceded by 0xF0 (break code).
REQ-012 SHALL have port key_valid  output  1  FIFO non-empty; head outputs are meaningful.
REQ-013 SHALL have port fifo_count  output  FIFO_AW+1  number of stored entries.
REQ-014 SHALL have port overflow  output  1  sticky flag: an entry was dropped because the FIFO was full.

Function
REQ-015 SHALL decode bytes with an FSM of states IDLE, EXT (0xE0 seen), REL (0xF0 seen) and EXT_REL (0xE0 then 0xF0 seen), advancing only on cycles with received_data_en=1.
REQ-016 SHALL apply these transitions: IDLE+E0 -> EXT; IDLE+F0 -> REL; EXT+F0 -> EXT_REL; EXT+E0 -> EXT (repeat ignored); REL+E0 -> EXT_REL; REL+F0 and EXT_REL+F0/E0 -> stay (repeat ignored).
REQ-017 SHALL treat any byte other than 0xE0/0xF0 as terminal: push {ext, rel, byte} with ext=1 in EXT/EXT_REL and rel=1 in REL/EXT_REL, then return to IDLE in the same cycle.
REQ-018 SHALL pass 0xAA, 0xFA, 0xFE, 0xEE, 0x00 and 0xFF received in IDLE through as ordinary terminal bytes (ext=0, rel=0).
REQ-019 SHALL run a 16-bit timeout counter while in any non-IDLE state, clearing it on every received_data_en; on reaching PREFIX_TIMEOUT it SHALL return to IDLE without pushing.
REQ-020 SHALL use a first-word-fall-through FIFO of 10-bit entries: key_code/key_extended/key_release always show the head entry, and key_valid=1 iff fifo_count>0.
REQ-021 SHALL make a terminal byte strobed in cycle N visible with key_valid=1 in cycle N+1 when the FIFO was empty (latency 1).
REQ-022 SHALL pop the head on a rising edge where key_read=1 and key_valid=1; key_read with key_valid=0 SHALL have no effect.
REQ-023 SHALL, on simultaneous push and pop, perform both, leaving fifo_count unchanged, including when the FIFO is full.
REQ-024 SHALL, on a push with the FIFO full and no pop, drop the new entry, leave the contents unchanged, and set overflow=1.
REQ-025 SHALL wrap the read/write pointers modulo 2**FIFO_AW; fifo_count SHALL range 0..2**FIFO_AW.
REQ-026 SHALL clear overflow on overflow_clear=1; if an overflow occurs in the same cycle, set SHALL win.
REQ-027 SHALL output key_code, key_extended and key_release as 0 while key_valid=0.

Reset
REQ-028 SHALL, while reset=0 and regardless of clk, force the FSM to IDLE and clear the timeout counter, the pointers, fifo_count, overflow and all outputs to 0.
REQ-029 SHALL discard any pending prefix and all FIFO contents on a mid-operation reset; the first strobe after release SHALL be decoded from IDLE.

Verification
REQ-030 SHALL verify: strobe 0x1C -> next cycle key_valid=1, key_code=0x1C, ext=0, rel=0, fifo_count=1.
REQ-031 SHALL verify: strobes E0, F0, 0x75 -> one entry code=0x75, ext=1, rel=1; prefixes push nothing.
REQ-032 SHALL verify: strobe F0 then no strobe for PREFIX_TIMEOUT cycles, then 0x1C -> entry 0x1C with rel=0.
REQ-033 SHALL verify: 9 terminal bytes 0x01..0x09 with no reads (FIFO_AW=3) -> fifo_count=8, overflow=1, reads return 0x01..0x08 in order.
REQ-034 SHALL verify: FIFO full, strobe 0x2A together with key_read=1 -> fifo_count stays 8, overflow stays 0, 0x2A appears as the last entry.
REQ-035 SHALL verify: F0 strobed, 3 entries queued, reset=0 asserted mid-clock -> all outputs 0 immediately; after release, strobe 0x1C -> entry rel=0.
